// File: rtl/bus_master_port.sv
// Initiator port between a core and the shared 4-master bus: request, address strobe,
// wait for slave ready (with optional timeout), return read data / error.
module bus_master_port #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic              core_busy,
    output logic              core_done,
    output logic              core_err,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              m_req_,
    input  logic              m_grnt_,
    output logic              m_as_,
    output logic              m_rw,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_rdy_
);

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

    state_t              state_q, state_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                as_n_q, as_n_d;
    logic                m_rw_q, m_rw_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wr_data_q, m_wr_data_d;
    logic                drive;

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rd_data_d = rd_data_q;

        unique case (state_q)
            IDLE: begin
                if (core_req) begin
                    rw_d    = core_rw;
                    addr_d  = core_addr;
                    wdata_d = core_wr_data;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!m_grnt_) begin
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS, WAIT: begin
                // Counter holds k in the k-th WAIT cycle, so expiry lands TIMEOUT+1 cycles
                // after ACCESS; a ready on that same cycle still wins.
                if (!m_rdy_) begin
                    done_d = 1'b1;
                    if (rw_q) begin
                        rd_data_d = m_rd_data;
                    end
                    state_d = IDLE;
                end else if (state_q == WAIT && TIMEOUT != 0 && cnt_q == TO_LIMIT) begin
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d   = cnt_q + TO_ONE;
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state; idle bus fields are zero for OR-muxing.
        drive       = (state_d == ACCESS) || (state_d == WAIT);
        busy_d      = (state_d != IDLE);
        as_n_d      = (state_d != ACCESS);
        m_rw_d      = drive ? rw_d : 1'b1;
        m_addr_d    = drive ? addr_d : '0;
        m_wr_data_d = drive ? wdata_d : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rw_q        <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            as_n_q      <= 1'b1;
            m_rw_q      <= 1'b1;
            m_addr_q    <= '0;
            m_wr_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            as_n_q      <= as_n_d;
            m_rw_q      <= m_rw_d;
            m_addr_q    <= m_addr_d;
            m_wr_data_q <= m_wr_data_d;
        end
    end

    assign core_busy    = busy_q;
    assign core_done    = done_q;
    assign core_err     = err_q;
    assign core_rd_data = rd_data_q;
    assign m_req_       = ~busy_q;
    assign m_as_        = as_n_q;
    assign m_rw         = m_rw_q;
    assign m_addr       = m_addr_q;
    assign m_wr_data    = m_wr_data_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: directed accesses with a slave/arbiter model.
module tb_bus_master_port;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_rw;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wr_data;
    logic          core_busy, core_done, core_err;
    logic [DW-1:0] core_rd_data;
    logic          m_req_, m_grnt_, m_as_, m_rw, m_rdy_;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wr_data, m_rd_data;

    bus_master_port #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(4),
        .TO_W   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_rw     (core_rw),
        .core_addr   (core_addr),
        .core_wr_data(core_wr_data),
        .core_busy   (core_busy),
        .core_done   (core_done),
        .core_err    (core_err),
        .core_rd_data(core_rd_data),
        .m_req_      (m_req_),
        .m_grnt_     (m_grnt_),
        .m_as_       (m_as_),
        .m_rw        (m_rw),
        .m_addr      (m_addr),
        .m_wr_data   (m_wr_data),
        .m_rd_data   (m_rd_data),
        .m_rdy_      (m_rdy_)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave: ready after slave_wait cycles counted from the strobe cycle.
    bit          active = 1'b0;
    int          wc = 0;
    int          slave_wait = 0;
    bit          slave_never = 1'b0;
    logic [31:0] slave_data = '0;

    always @(negedge clk) begin
        if (m_as_ === 1'b0) begin
            active = 1'b1;
            wc = 0;
        end else if (active && m_req_ === 1'b0) begin
            wc++;
        end else begin
            active = 1'b0;
        end
        if (active && !slave_never && wc == slave_wait) begin
            m_rdy_    = 1'b0;
            m_rd_data = slave_data;
        end else begin
            m_rdy_    = 1'b1;
            m_rd_data = 32'hBAD0_BAD0;
        end
    end

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (core_done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 128'(cyc), 128'(e.cyc));
                chk("rd_data", 128'(core_rd_data), 128'(e.data));
                chk("err", 128'(core_err), 128'(e.err));
            end
        end
    end

    task automatic run_until_done(input string name, output int as_low);
        bit seen;
        seen   = 1'b0;
        as_low = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (m_as_ === 1'b0) as_low++;
            if (core_done === 1'b1) seen = 1'b1;
        end
        chk(name, 128'(seen), 128'(1));
    endtask

    task automatic issue(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        core_req     = 1'b1;
        core_rw      = rw;
        core_addr    = addr;
        core_wr_data = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int as_low;
        int d0;

        reset = 1'b0; core_req = 1'b0; core_rw = 1'b1; core_addr = '0; core_wr_data = '0;
        m_grnt_ = 1'b0; m_rdy_ = 1'b1; m_rd_data = '0;

        @(negedge clk);
        chk("reset_ctl", {m_req_, m_as_, m_rw, core_busy, core_done, core_err}, 6'b111000);
        chk("reset_bus", {m_addr, m_wr_data, core_rd_data}, '0);
        reset = 1'b1;
        @(negedge clk);

        // Parked grant, zero-wait READ.
        slave_data = 32'hDEAD_BEEF; slave_wait = 0;
        @(negedge clk);
        c = cyc;
        sb.push_back('{32'hDEAD_BEEF, 1'b0, c + 3});
        issue(1'b1, 30'h100, 32'h0);
        @(negedge clk);
        core_req = 1'b0;
        chk("t1_accept", {core_busy, m_req_, m_as_}, 3'b101);
        @(negedge clk);
        chk("t1_access", {m_as_, m_rw, m_addr}, {1'b0, 1'b1, 30'h100});
        run_until_done("t1_done_seen", as_low);
        chk("t1_as_cycles", 128'(as_low + 1), 128'(1));
        chk("t1_release", {m_req_, core_busy}, 2'b10);

        // WRITE while another master owns the bus for 5 cycles.
        @(negedge clk);
        m_grnt_ = 1'b1; slave_wait = 2;
        c = cyc;
        sb.push_back('{32'hDEAD_BEEF, 1'b0, c + 9});
        issue(1'b0, 30'h3FF, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            core_req = 1'b0;
            chk("t2_req_phase", {m_req_, m_as_, m_rw, m_addr, m_wr_data}, {1'b0, 1'b1, 1'b1, 30'h0, 32'h0});
        end
        m_grnt_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_bus_hold", {m_req_, m_as_, m_rw, m_addr, m_wr_data},
                {1'b0, (i == 0) ? 1'b0 : 1'b1, 1'b0, 30'h3FF, 32'h1234_5678});
        end
        run_until_done("t2_done_seen", as_low);
        chk("t2_release", {m_req_, m_addr, m_wr_data}, {1'b1, 30'h0, 32'h0});

        // Timeout: slave never answers.
        @(negedge clk);
        slave_never = 1'b1;
        c = cyc;
        sb.push_back('{32'h0, 1'b1, c + 7});
        issue(1'b1, 30'h55, 32'h0);
        @(negedge clk);
        core_req = 1'b0;
        run_until_done("t3_done_seen", as_low);
        chk("t3_as_cycles", 128'(as_low), 128'(1));
        chk("t3_release", {m_req_, core_busy}, 2'b10);

        // Ready lands exactly on the terminal-count cycle.
        @(negedge clk);
        slave_never = 1'b0; slave_wait = 4; slave_data = 32'hA5A5_0004;
        c = cyc;
        sb.push_back('{32'hA5A5_0004, 1'b0, c + 7});
        issue(1'b1, 30'h77, 32'h0);
        @(negedge clk);
        core_req = 1'b0;
        run_until_done("t4_done_seen", as_low);

        // Back-to-back READ then WRITE with core_req held high.
        @(negedge clk);
        slave_wait = 0; slave_data = 32'h1111_2222;
        d0 = done_cnt;
        c = cyc;
        sb.push_back('{32'h1111_2222, 1'b0, c + 3});
        sb.push_back('{32'h1111_2222, 1'b0, c + 6});
        issue(1'b1, 30'h10, 32'h0);
        @(negedge clk);
        core_rw = 1'b0; core_addr = 30'h20; core_wr_data = 32'h5555_AAAA;
        @(negedge clk);
        @(negedge clk);
        chk("t5_first_done", {core_done, core_busy}, 2'b10);
        @(negedge clk);
        chk("t5_second_accept", {core_busy, m_req_}, 2'b10);
        @(negedge clk);
        chk("t5_second_access", {m_as_, m_rw, m_addr, m_wr_data}, {1'b0, 1'b0, 30'h20, 32'h5555_AAAA});
        @(negedge clk);
        core_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_done_pulses", 128'(done_cnt - d0), 128'(2));

        // Asynchronous reset in the middle of WAIT.
        @(negedge clk);
        slave_never = 1'b1;
        issue(1'b1, 30'h2A, 32'h0);
        @(negedge clk);
        core_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_in_wait", {core_busy, m_as_, m_addr}, {1'b1, 1'b1, 30'h2A});
        #2 reset = 1'b0;
        #1;
        chk("t6_reset_ctl", {m_req_, m_as_, m_rw, core_busy, core_done, core_err}, 6'b111000);
        chk("t6_reset_bus", {m_addr, m_wr_data, core_rd_data}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        slave_never = 1'b0; slave_wait = 1; slave_data = 32'hCAFE_0001;
        @(negedge clk);
        c = cyc;
        sb.push_back('{32'hCAFE_0001, 1'b0, c + 4});
        issue(1'b1, 30'h2A, 32'h0);
        @(negedge clk);
        core_req = 1'b0;
        run_until_done("t6_done_seen", as_low);

        repeat (3) @(negedge clk);
        chk("sb_empty", 128'(sb.size()), 128'(0));
        chk("total_done", 128'(done_cnt), 128'(7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
